mini_aes_iter: RTL and testbench

MINI_AES_ITER -- requirements
Module: mini_aes_iter

---
 rtl/mini_aes_iter.sv | 212 +++++++++++++++++++++
 tb/tb_mini_aes_iter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_aes_iter.sv
// mini_aes_iter: iterative Mini-AES (16-bit block) cipher, one round per clock, LANES blocks under one key.
// Optional decryption is built when MINI_AES_DECRYPT_EN is defined (adds the 'mode' port).
module mini_aes_iter #(
    parameter int LANES  = 1,
    parameter int ROUNDS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef MINI_AES_DECRYPT_EN
    input  logic                mode,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*LANES-1:0] in_state,
    input  logic [15:0]         in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*LANES-1:0] out_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] KEXP  = 2'd3;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hD;  4'h3: y = 4'h1;
            4'h4: y = 4'h2;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h8;
            4'h8: y = 4'h3;  4'h9: y = 4'hA;  4'hA: y = 4'h6;  4'hB: y = 4'hC;
            4'hC: y = 4'h5;  4'hD: y = 4'h9;  4'hE: y = 4'h0;  default: y = 4'h7;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h3;  4'h2: y = 4'h4;  4'h3: y = 4'h8;
            4'h4: y = 4'h1;  4'h5: y = 4'hC;  4'h6: y = 4'hA;  4'h7: y = 4'hF;
            4'h8: y = 4'h7;  4'h9: y = 4'hD;  4'hA: y = 4'h9;  4'hB: y = 4'h6;
            4'hC: y = 4'hB;  4'hD: y = 4'h2;  4'hE: y = 4'h0;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    // rcon(r) = x^(r-1) reduced mod x^4+x+1
    function automatic logic [3:0] rcon(input logic [3:0] r);
        logic [3:0] y;
        case (r)
            4'd1: y = 4'h1;  4'd2: y = 4'h2;  4'd3: y = 4'h4;  4'd4: y = 4'h8;
            4'd5: y = 4'h3;  4'd6: y = 4'h6;  4'd7: y = 4'hC;  4'd8: y = 4'hB;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] xtime(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [15:0] nib_sub(input logic [15:0] s);
        return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] inv_nib_sub(input logic [15:0] s);
        return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] shift_row(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [7:0] mix_one(input logic [3:0] a, input logic [3:0] b);
        return {xtime(a) ^ a ^ xtime(b), xtime(a) ^ xtime(b) ^ b};
    endfunction

    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {mix_one(s[15:12], s[11:8]), mix_one(s[7:4], s[3:0])};
    endfunction

    function automatic logic [15:0] key_next(input logic [15:0] k, input logic [3:0] rc);
        logic [3:0] w4, w5, w6, w7;
        w4 = k[15:12] ^ sbox(k[3:0]) ^ rc;
        w5 = k[11:8] ^ w4;
        w6 = k[7:4] ^ w5;
        w7 = k[3:0] ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    function automatic logic [15:0] key_prev(input logic [15:0] k, input logic [3:0] rc);
        logic [3:0] w0, w1, w2, w3;
        w3 = k[3:0] ^ k[7:4];
        w2 = k[7:4] ^ k[11:8];
        w1 = k[11:8] ^ k[15:12];
        w0 = k[15:12] ^ sbox(w3) ^ rc;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [15:0] enc_round(input logic [15:0] s, input logic [15:0] k,
                                              input logic last);
        logic [15:0] t;
        t = shift_row(nib_sub(s));
        if (!last) t = mix_col(t);
        return t ^ k;
    endfunction

    // MixColumn is its own inverse, so it leads every inverse round except the first
    function automatic logic [15:0] dec_round(input logic [15:0] s, input logic [15:0] k,
                                              input logic mix);
        logic [15:0] t;
        t = mix ? mix_col(s) : s;
        return shift_row(inv_nib_sub(t)) ^ k;
    endfunction

    logic [1:0]          fsm;
    logic [3:0]          rnd;
    logic [16*LANES-1:0] st;
    logic [15:0]         key;
    logic [16*LANES-1:0] res;
    logic                dec;
    logic                start_dec;

    logic [15:0]         key_fwd;
    logic [15:0]         key_bwd;
    logic [16*LANES-1:0] enc_next;
    logic [16*LANES-1:0] dec_next;

    always_comb begin
        key_fwd  = key_next(key, rcon(rnd + 4'd1));
        key_bwd  = key_prev(key, rcon(4'(ROUNDS) - rnd));
        enc_next = '0;
        dec_next = '0;
        for (int i = 0; i < LANES; i++) begin
            enc_next[16*i +: 16] = enc_round(st[16*i +: 16], key_fwd, rnd == LAST);
            dec_next[16*i +: 16] = dec_round(st[16*i +: 16], key_bwd, rnd != 4'd0);
        end
    end

`ifdef MINI_AES_DECRYPT_EN
    assign start_dec = mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec <= 1'b0;
        end else if (fsm == IDLE && in_valid) begin
            dec <= mode;
        end
    end
`else
    assign start_dec = 1'b0;
    assign dec       = 1'b0;
`endif

    // Decrypt walks the key schedule forward in KEXP, then regenerates earlier keys backwards in ROUND
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm <= IDLE;
            rnd <= '0;
            st  <= '0;
            key <= '0;
            res <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        key <= in_key;
                        rnd <= '0;
                        if (start_dec) begin
                            st  <= in_state;
                            fsm <= KEXP;
                        end else begin
                            st  <= in_state ^ {LANES{in_key}};
                            fsm <= ROUND;
                        end
                    end
                end
                KEXP: begin
                    key <= key_fwd;
                    if (rnd == LAST) begin
                        rnd <= '0;
                        st  <= st ^ {LANES{key_fwd}};
                        fsm <= ROUND;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ROUND: begin
                    st  <= dec ? dec_next : enc_next;
                    key <= dec ? key_bwd : key_fwd;
                    rnd <= rnd + 4'd1;
                    if (rnd == LAST) begin
                        res <= dec ? dec_next : enc_next;
                        fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign out_data  = res;

endmodule

// File: tb/tb_mini_aes_iter.sv
// tb_mini_aes_iter: self-checking bench for mini_aes_iter (LANES=2/ROUNDS=2 main instance, LANES=1/ROUNDS=8 second instance).
// Expected values come from spec vectors and a matrix-level Mini-AES model.
module tb_mini_aes_iter;

    localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                                         4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};

    typedef struct {
        logic [31:0] st;
        logic [15:0] key;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_state = '0;
    logic [15:0] in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_state = '0;
    logic [15:0] b_in_key = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [15:0] b_out_data;

`ifdef MINI_AES_DECRYPT_EN
    logic        mode = 1'b0;
    logic        b_mode = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mini_aes_iter #(.LANES(2), .ROUNDS(2)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MINI_AES_DECRYPT_EN
        .mode(mode),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    mini_aes_iter #(.LANES(1), .ROUNDS(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef MINI_AES_DECRYPT_EN
        .mode(b_mode),
`endif
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state), .in_key(b_in_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Carry-less polynomial product reduced by x^4+x+1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) if (b[i]) p ^= 8'(a) << i;
        for (int i = 7; i >= 4; i--) if (p[i]) p ^= 8'h13 << (i - 4);
        return p[3:0];
    endfunction

    function automatic logic [15:0] ref_encrypt(input logic [15:0] p, input logic [15:0] k,
                                                input int rounds);
        logic [3:0] w [36];
        logic [3:0] n [4];
        logic [3:0] t [4];
        logic [3:0] rc;
        logic [3:0] tmp;
        for (int i = 0; i < 4; i++) begin
            w[i] = k[15 - 4*i -: 4];
            n[i] = p[15 - 4*i -: 4] ^ w[i];
        end
        rc = 4'h1;
        for (int r = 1; r <= rounds; r++) begin
            w[4*r]     = w[4*r - 4] ^ SBOX[w[4*r - 1]] ^ rc;
            w[4*r + 1] = w[4*r - 3] ^ w[4*r];
            w[4*r + 2] = w[4*r - 2] ^ w[4*r + 1];
            w[4*r + 3] = w[4*r - 1] ^ w[4*r + 2];
            for (int i = 0; i < 4; i++) n[i] = SBOX[n[i]];
            tmp = n[1]; n[1] = n[3]; n[3] = tmp;
            if (r != rounds) begin
                for (int c = 0; c < 2; c++) begin
                    t[2*c]     = gf_mul(4'h3, n[2*c]) ^ gf_mul(4'h2, n[2*c + 1]);
                    t[2*c + 1] = gf_mul(4'h2, n[2*c]) ^ gf_mul(4'h3, n[2*c + 1]);
                end
                for (int i = 0; i < 4; i++) n[i] = t[i];
            end
            for (int i = 0; i < 4; i++) n[i] ^= w[4*r + i];
            rc = gf_mul(rc, 4'h2);
        end
        return {n[0], n[1], n[2], n[3]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one job for exactly one accepting edge
    task automatic applyStimulus(input logic [31:0] s, input logic [15:0] k);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_state = s;
        in_key   = k;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("busy_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic runJob(input string name, input logic [31:0] s, input logic [15:0] k,
                          input logic [31:0] exp, input int latency);
        int lat = 0;
        applyStimulus(s, k);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_latency"}, lat, latency);
        checkOutput({name, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, "_release"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic runJobB(input logic [15:0] s, input logic [15:0] k);
        int lat = 0;
        logic [15:0] exp;
        exp = ref_encrypt(s, k, 8);
        b_in_state = s;
        b_in_key   = k;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        while (!b_out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("r8_latency", lat, 8);
        checkOutput("r8_data", {16'd0, b_out_data}, {16'd0, exp});
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs [7];
        logic [31:0] s;
        logic [15:0] k;
        int          lat;
        int          seen;

        vecs[0] = '{32'h9C639C63, 16'hC3F0, 32'h72C672C6};
        vecs[1] = '{32'h00000000, 16'h0000, {ref_encrypt(16'h0000, 16'h0000, 2), ref_encrypt(16'h0000, 16'h0000, 2)}};
        vecs[2] = '{32'hFFFFFFFF, 16'hFFFF, {ref_encrypt(16'hFFFF, 16'hFFFF, 2), ref_encrypt(16'hFFFF, 16'hFFFF, 2)}};
        for (int i = 3; i < 7; i++) begin
            s = $urandom;
            k = 16'($urandom_range(0, 65535));
            vecs[i] = '{s, k, {ref_encrypt(s[31:16], k, 2), ref_encrypt(s[15:0], k, 2)}};
        end

        @(posedge clk); #1;
        checkOutput("reset_state", {in_ready, out_valid, 30'd0}, {1'b1, 1'b0, 30'd0});
        checkOutput("reset_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            runJob($sformatf("vec%0d", i), vecs[i].st, vecs[i].key, vecs[i].exp, 2);
        end

        // Backpressure with an in_valid pulse that must be ignored while DONE
        applyStimulus(32'h9C639C63, 16'hC3F0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp_latency", lat, 2);
        in_state = 32'h0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_data", out_data, 32'h72C672C6);
            checkOutput("bp_flags", {30'd0, in_ready, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_release", {30'd0, in_ready, out_valid}, 32'd2);

        // in_valid with zero state during ROUND must not disturb the job
        applyStimulus(32'h9C639C63, 16'hC3F0);
        in_state = 32'h0;
        in_key   = 16'h0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("ign_latency", lat, 2);
        checkOutput("ign_data", out_data, 32'h72C672C6);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("ign_no_second_valid", seen, 0);

        // Reset for one edge in the middle of ROUND discards the job
        applyStimulus(32'h9C639C63, 16'hC3F0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("rst_flags", {30'd0, in_ready, out_valid}, 32'd2);
        checkOutput("rst_data", out_data, 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid || out_data != 32'd0) seen++;
            @(posedge clk); #1;
        end
        checkOutput("rst_no_stale", seen, 0);
        runJob("after_rst", 32'h9C639C63, 16'hC3F0, 32'h72C672C6, 2);

        // Eight-round single-lane instance exercises every rcon value
        runJobB(16'h9C63, 16'hC3F0);
        for (int i = 0; i < 4; i++) begin
            runJobB(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end

`ifdef MINI_AES_DECRYPT_EN
        mode = 1'b1;
        runJob("dec_vec", 32'h72C672C6, 16'hC3F0, 32'h9C639C63, 4);
        for (int i = 0; i < 3; i++) begin
            s = $urandom;
            k = 16'($urandom_range(0, 65535));
            runJob("dec_rand", {ref_encrypt(s[31:16], k, 2), ref_encrypt(s[15:0], k, 2)}, k, s, 4);
        end
        mode = 1'b0;
        runJob("enc_after_dec", 32'h9C639C63, 16'hC3F0, 32'h72C672C6, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
